pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences each instruction: fetch from instruction memory
//  via a req/ack handshake, hold the instruction for the core, then select the next PC
//  (sequential, PC-relative branch, CBZ/CBNZ, register branch) on execute-done.
//  Sits between the instruction memory port and the decode/ALU datapath. Replaces the free-running PC register.
// PARAMETERS
//  ADDR_W     64            PC / address width
//  INSTR_W    32            instruction word width
//  RESET_PC   64'h0         PC value loaded on reset
//  RETIRE_W   32            width of retired-instruction counter
// PORTS
//  Clk         in   1         clock; all state updates on posedge
//  Rst         in   1         synchronous, active-high reset
//  Run         in   1         1 = keep issuing instructions; 0 = stop at next instruction boundary
//  imem_req    out  1         fetch request, held until imem_ack
//  imem_addr   out  ADDR_W    fetch address (= PC), stable while imem_req=1
//  imem_ack    in   1         fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   INSTR_W   fetched instruction word
//  instr       out  INSTR_W   latched instruction for decode
//  instr_valid out  1         instr valid; held until exec_done
//  exec_done   in   1         core has resolved branch inputs for instr (sampled only when instr_valid=1)
//  Branch      in   1         CBZ: taken when ALUZero=1
//  BranchNZ    in   1         CBNZ: taken when ALUZero=0
//  UncondBr    in   1         B: always taken, PC-relative
//  BranchReg   in   1         BR: target = RegTarget
//  ALUZero     in   1         ALU zero flag
//  SignExt     in   ADDR_W    sign-extended word offset
//  RegTarget   in   ADDR_W    register branch target
//  PC          out  ADDR_W    current PC
//  retired     out  RETIRE_W  instructions completed, wraps modulo 2^RETIRE_W
//  fault       out  1         misaligned-target trap (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, PC=RESET_PC, imem_req=0, instr=0, instr_valid=0, retired=0, fault=0.
//  Rst wins over every simultaneous event, any state, mid-fetch included (pending fetch dropped).
//  States: IDLE, FETCH, EXEC, FAULT.
//  IDLE : imem_req=0. Run=1 -> FETCH next cycle.
//  FETCH: imem_req=1, imem_addr=PC. imem_ack=1 -> instr<=imem_rdata, instr_valid<=1, -> EXEC.
//         Run dropping in FETCH does not abort; the fetch completes.
//  EXEC : instr_valid=1. exec_done=1 -> PC<=next_pc, retired++, instr_valid<=0,
//         then -> FETCH if Run=1 else IDLE.
//  next_pc priority: BranchReg -> RegTarget; UncondBr -> PC+(SignExt<<2);
//         (Branch&ALUZero)|(BranchNZ&~ALUZero) -> PC+(SignExt<<2); else PC+4.
//  Arithmetic modulo 2^ADDR_W; SignExt<<2 drops top 2 bits; wrap at all-ones is legal.
//  Min throughput: ack in first FETCH cycle, exec_done in first EXEC cycle -> 2 cycles/instr.
//  imem_ack outside FETCH, exec_done outside EXEC: ignored.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: next_pc[1:0]!=0 -> state FAULT, fault=1, PC unchanged,
//    retired not incremented, imem_req=0; FAULT exits only via Rst.
//  PC_MISALIGN_TRAP_EN undefined: next_pc[1:0] forced to 2'b00; FAULT unreachable; fault tied 0.
// STRUCTURE
//  pc_seq_pkg: state enum (IDLE/FETCH/EXEC/FAULT), PC_INCR=4, BR_SHIFT=2, default widths.
//  Sub-module pc_next_calc: combinational next_pc select/adders + misalign flag;
//    FSM, PC register and retire counter stay in the top.
// TESTING
//  Rst, Run=1, ack same cycle, exec_done same cycle, no branch -> imem_addr 0,4,8; retired=3 after 6 cycles.
//  PC=0x100, Branch=1, ALUZero=1, SignExt=-2 -> next PC 0xF8; ALUZero=0 -> 0x104; BranchNZ=1, ALUZero=0 -> 0xF8.
//  BranchReg=1 with UncondBr=1, RegTarget=0x2000 -> PC=0x2000 (register wins).
//  ack delayed 3 cycles -> imem_req/imem_addr stable; Run=0 during wait -> fetch completes, IDLE after exec_done.
//  Rst in EXEC with exec_done=1 -> PC=RESET_PC, retired=0, instr_valid=0 next cycle.
//  RegTarget=0x2002: TRAP_EN -> fault=1, PC held, req=0 until Rst; without -> PC=0x2000.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer slice.
//   seq_state_e : sequencer FSM states (IDLE/FETCH/EXEC/FAULT)
//   PC_INCR     : sequential PC step in bytes
//   BR_SHIFT    : word-offset to byte-offset shift for PC-relative branches
//   DEF_*       : default widths shared by the top, the sub-module and the interface
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } seq_state_e;

  localparam int unsigned PC_INCR      = 4;
  localparam int unsigned BR_SHIFT     = 2;
  localparam int unsigned DEF_ADDR_W   = 64;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_RETIRE_W = 32;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port (req/ack handshake).
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req=1
//   imem_ack   : fetch complete, imem_rdata valid in the same cycle
//   imem_rdata : fetched instruction word
// Modports: master = sequencer side, slave = memory side.
interface pc_fetch_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection.
//   pc, sign_ext, reg_target : current PC, word offset, register target
//   branch/branch_nz/uncond_br/branch_reg/alu_zero : branch controls
//   next_pc    : raw selected next PC (low bits untouched)
//   misaligned : next_pc[1:0] != 0
// Priority: register branch, unconditional, taken conditional, sequential.
module pc_next_calc
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sign_ext,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              branch,
  input  logic              branch_nz,
  input  logic              uncond_br,
  input  logic              branch_reg,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic              cond_taken;

  // Shift drops the top BR_SHIFT bits of the offset; sums wrap modulo 2^ADDR_W.
  assign seq_pc     = pc + ADDR_W'(PC_INCR);
  assign rel_pc     = pc + (sign_ext << BR_SHIFT);
  assign cond_taken = (branch & alu_zero) | (branch_nz & ~alu_zero);

  always_comb begin
    next_pc = seq_pc;
    if (branch_reg)                   next_pc = reg_target;
    else if (uncond_br || cond_taken) next_pc = rel_pc;
    misaligned = |next_pc[1:0];
  end
endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction sequencer: fetches from imem via req/ack, holds the
// instruction for the core, then loads the next PC on exec_done.
// Ports: Clk/Rst (sync, active-high), Run, imem (fetch interface, master),
//   instr/instr_valid to decode, exec_done + branch controls from the core,
//   PC, retired counter, fault.
// Option macro PC_MISALIGN_TRAP_EN: misaligned next PC traps into FAULT
//   (exit only via Rst); when undefined the low two target bits are cleared.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       RETIRE_W = DEF_RETIRE_W
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Run,
  pc_fetch_sequencer_if.master imem,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                Branch,
  input  logic                BranchNZ,
  input  logic                UncondBr,
  input  logic                BranchReg,
  input  logic                ALUZero,
  input  logic [ADDR_W-1:0]   SignExt,
  input  logic [ADDR_W-1:0]   RegTarget,
  output logic [ADDR_W-1:0]   PC,
  output logic [RETIRE_W-1:0] retired,
  output logic                fault
);
  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                imem_req_q, imem_req_d;
  logic                fault_q, fault_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [ADDR_W-1:0]   next_pc_raw;
  logic                next_misaligned;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
    .pc         (pc_q),
    .sign_ext   (SignExt),
    .reg_target (RegTarget),
    .branch     (Branch),
    .branch_nz  (BranchNZ),
    .uncond_br  (UncondBr),
    .branch_reg (BranchReg),
    .alu_zero   (ALUZero),
    .next_pc    (next_pc_raw),
    .misaligned (next_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    fault_d       = fault_q;
    retired_d     = retired_q;
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end
      end
      FETCH: begin
        // Run is not consulted here: an issued fetch always completes.
        if (imem.imem_ack) begin
          state_d       = EXEC;
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
        end
      end
      EXEC: begin
        if (exec_done) begin
          instr_valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          if (next_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d    = Run ? FETCH : IDLE;
            imem_req_d = Run;
            pc_d       = next_pc_raw;
            retired_d  = retired_q + RETIRE_W'(1);
          end
`else
          state_d    = Run ? FETCH : IDLE;
          imem_req_d = Run;
          pc_d       = next_misaligned ? {next_pc_raw[ADDR_W-1:2], 2'b00} : next_pc_raw;
          retired_d  = retired_q + RETIRE_W'(1);
`endif
        end
      end
      FAULT: begin
        imem_req_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fault_q       <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fault_q       <= fault_d;
      retired_q     <= retired_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign PC             = pc_q;
  assign retired        = retired_q;
  assign fault          = fault_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus randomized instruction
// stream against a transaction-level PC/retire model.
module tb_pc_fetch_sequencer;
  logic        Clk = 1'b0;
  logic        Rst, Run, exec_done;
  logic        Branch, BranchNZ, UncondBr, BranchReg, ALUZero;
  logic [63:0] SignExt, RegTarget, PC;
  logic [31:0] instr, retired;
  logic        instr_valid, fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] m_pc;
  logic [31:0] m_retired;

  always #5 Clk = ~Clk;

  pc_fetch_sequencer_if #(.ADDR_W(64), .INSTR_W(32)) imem_bus ();

  pc_fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .RETIRE_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .imem(imem_bus.master),
    .instr(instr), .instr_valid(instr_valid), .exec_done(exec_done),
    .Branch(Branch), .BranchNZ(BranchNZ), .UncondBr(UncondBr), .BranchReg(BranchReg),
    .ALUZero(ALUZero), .SignExt(SignExt), .RegTarget(RegTarget),
    .PC(PC), .retired(retired), .fault(fault)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    Branch = 0; BranchNZ = 0; UncondBr = 0; BranchReg = 0; ALUZero = 0;
    SignExt = '0; RegTarget = '0;
  endtask

  task automatic do_reset();
    Rst = 1; Run = 0; exec_done = 0; imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    clear_ctl();
    @(negedge Clk);
    Rst = 0;
    m_pc = 64'h0; m_retired = '0;
    check("rst_pc", PC, 64'h0);
    check("rst_req", {63'b0, imem_bus.imem_req}, 64'd0);
    check("rst_valid", {63'b0, instr_valid}, 64'd0);
    check("rst_instr", {32'b0, instr}, 64'd0);
    check("rst_retired", {32'b0, retired}, 64'd0);
    check("rst_fault", {63'b0, fault}, 64'd0);
  endtask

  // Architectural next-PC rule, expressed directly from the ISA description.
  function automatic logic [63:0] model_target(input bit br, bnz, ub, brg, z,
                                               input logic [63:0] se, rt, pc);
    if (brg) return rt;
    if (ub || (br && z) || (bnz && !z)) return pc + se * 64'd4;
    return pc + 64'd4;
  endfunction

  // One instruction: wait for fetch, ack after ack_dly cycles, exec_done after done_dly.
  task automatic run_instr(input bit br, bnz, ub, brg, z, input logic [63:0] se, rt,
                           input int unsigned ack_dly, done_dly, input bit run_after);
    logic [31:0] word;
    logic [63:0] tgt;
    int unsigned w;
    Run = 1;
    w = 0;
    while (imem_bus.imem_req !== 1'b1 && w < 8) begin
      @(negedge Clk);
      w++;
    end
    check("req_seen", {63'b0, imem_bus.imem_req}, 64'd1);
    if (imem_bus.imem_req !== 1'b1) return;
    check("fetch_addr", imem_bus.imem_addr, m_pc);
    Run = run_after;
    for (int unsigned i = 0; i < ack_dly; i++) begin
      exec_done = 1'($urandom_range(0, 1));  // must be ignored outside EXEC
      BranchReg = 1; RegTarget = 64'h5550;
      @(negedge Clk);
      check("wait_req", {63'b0, imem_bus.imem_req}, 64'd1);
      check("wait_addr", imem_bus.imem_addr, m_pc);
      check("wait_pc", PC, m_pc);
    end
    clear_ctl();
    exec_done = 0;
    word = $urandom;
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = word;
    @(negedge Clk);
    imem_bus.imem_ack = 0;
    check("instr_valid", {63'b0, instr_valid}, 64'd1);
    check("instr", {32'b0, instr}, {32'b0, word});
    check("req_drop", {63'b0, imem_bus.imem_req}, 64'd0);
    Branch = br; BranchNZ = bnz; UncondBr = ub; BranchReg = brg; ALUZero = z;
    SignExt = se; RegTarget = rt;
    for (int unsigned i = 0; i < done_dly; i++) begin
      imem_bus.imem_ack = 1'($urandom_range(0, 1));  // must be ignored outside FETCH
      imem_bus.imem_rdata = ~word;
      @(negedge Clk);
      check("hold_instr", {32'b0, instr}, {32'b0, word});
      check("hold_valid", {63'b0, instr_valid}, 64'd1);
    end
    imem_bus.imem_ack = 0;
    exec_done = 1;
    @(negedge Clk);
    exec_done = 0;
    clear_ctl();
    tgt = model_target(br, bnz, ub, brg, z, se, rt, m_pc);
`ifdef PC_MISALIGN_TRAP_EN
    if (tgt[1:0] != 2'b00) begin
      check("trap_fault", {63'b0, fault}, 64'd1);
      check("trap_pc", PC, m_pc);
      check("trap_req", {63'b0, imem_bus.imem_req}, 64'd0);
      check("trap_retired", {32'b0, retired}, {32'b0, m_retired});
      return;
    end
`endif
    m_pc = tgt & ~64'd3;
    m_retired = m_retired + 32'd1;
    check("next_pc", PC, m_pc);
    check("retired", {32'b0, retired}, {32'b0, m_retired});
    check("done_valid", {63'b0, instr_valid}, 64'd0);
    check("next_req", {63'b0, imem_bus.imem_req}, {63'b0, run_after});
    check("no_fault", {63'b0, fault}, 64'd0);
  endtask

  initial begin
    logic [63:0] addrs[$];
    Rst = 1; Run = 0; exec_done = 0;
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    clear_ctl();
    @(negedge Clk);
    do_reset();

    // Back-to-back throughput: ack and exec_done held high, sequential flow.
    Run = 1; imem_bus.imem_ack = 1; exec_done = 1; imem_bus.imem_rdata = 32'h1234;
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk);
      if (imem_bus.imem_req === 1'b1) addrs.push_back(imem_bus.imem_addr);
      if (c == 4) check("tp_retired_5cyc", {32'b0, retired}, 64'd2);
    end
    imem_bus.imem_ack = 0; exec_done = 0;
    check("tp_nfetch", 64'(addrs.size()), 64'd4);
    if (addrs.size() >= 3) begin
      check("tp_addr0", addrs[0], 64'h0);
      check("tp_addr1", addrs[1], 64'h4);
      check("tp_addr2", addrs[2], 64'h8);
    end
    check("tp_retired", {32'b0, retired}, 64'd3);
    m_pc = 64'hC; m_retired = 32'd3;

    // Conditional branch cases from PC 0x100.
    run_instr(0,0,0,1,0, 64'h0, 64'h100, 0, 0, 1);
    run_instr(1,0,0,0,1, -64'sd2, 64'h0, 1, 1, 1);   // CBZ taken -> 0xF8
    run_instr(0,0,0,1,0, 64'h0, 64'h100, 0, 0, 1);
    run_instr(1,0,0,0,0, -64'sd2, 64'h0, 0, 2, 1);   // CBZ not taken -> 0x104
    run_instr(0,0,0,1,0, 64'h0, 64'h100, 0, 0, 1);
    run_instr(0,1,0,0,0, -64'sd2, 64'h0, 2, 0, 1);   // CBNZ taken -> 0xF8
    run_instr(0,0,1,1,0, 64'h10, 64'h2000, 0, 0, 1); // register beats unconditional
    // Delayed ack with Run dropped during the wait: completes, then IDLE.
    run_instr(0,0,0,0,0, 64'h0, 64'h0, 3, 0, 0);
    repeat (2) @(negedge Clk);
    check("idle_req", {63'b0, imem_bus.imem_req}, 64'd0);
    // Wrap at the top of the address space.
    run_instr(0,0,0,1,0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1);
    run_instr(0,0,0,0,0, 64'h0, 64'h0, 0, 0, 1);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [63:0] se, rt;
      int unsigned kind;
      kind = $urandom_range(0, 4);
      se = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                       : 64'($signed(7'($urandom)));
      rt = {$urandom, $urandom};
`ifdef PC_MISALIGN_TRAP_EN
      rt = rt & ~64'd3;
`endif
      run_instr(kind == 0, kind == 1, kind == 2, ($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), se, rt,
                $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) != 0));
    end

    // Rst in EXEC coinciding with exec_done.
    run_instr(0,0,0,1,0, 64'h0, 64'h300, 0, 0, 1);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'hAA55;
    @(negedge Clk);
    imem_bus.imem_ack = 0;
    exec_done = 1; Rst = 1;
    @(negedge Clk);
    exec_done = 0; Rst = 0; Run = 0;
    check("rexec_pc", PC, 64'h0);
    check("rexec_retired", {32'b0, retired}, 64'd0);
    check("rexec_valid", {63'b0, instr_valid}, 64'd0);
    m_pc = 64'h0; m_retired = '0;

    // Rst mid-fetch with a simultaneous ack: fetch is dropped.
    Run = 1;
    repeat (2) @(negedge Clk);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'hDEAD; Rst = 1;
    @(negedge Clk);
    imem_bus.imem_ack = 0; Rst = 0; Run = 0;
    check("rfetch_valid", {63'b0, instr_valid}, 64'd0);
    check("rfetch_instr", {32'b0, instr}, 64'd0);
    check("rfetch_req", {63'b0, imem_bus.imem_req}, 64'd0);

    // Misaligned register target.
    run_instr(0,0,0,1,0, 64'h0, 64'h2002, 0, 0, 1);
`ifdef PC_MISALIGN_TRAP_EN
    repeat (3) @(negedge Clk);
    check("fault_hold", {63'b0, fault}, 64'd1);
    check("fault_pc", PC, m_pc);
    check("fault_req", {63'b0, imem_bus.imem_req}, 64'd0);
    do_reset();
`else
    check("align_pc", PC, 64'h2000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
